regfile_wr_sched: RTL and testbench

REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

---
 rtl/regfile_wr_sched_pkg.sv | 34 +++
 rtl/regfile_wr_sched_wb_fifo.sv | 65 ++++++
 rtl/regfile_wr_sched.sv | 152 +++++++++++++++
 tb/tb_regfile_wr_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_sched_pkg.sv
// Shared register-file definitions for the write-port scheduler:
// address/data widths, buffer defaults and the write-source encoding.
package regfile_wr_sched_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int REG_DATA_W       = 32;
  localparam int REG_NUM          = 32;
  localparam int ENTRY_W          = REG_ADDR_W + REG_DATA_W;
  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wr_src_e;

  // One-hot register mask; register 0 is hardwired so it never maps to a bit.
  function automatic logic [REG_NUM-1:0] addr_onehot(input reg_addr_t a);
    logic [REG_NUM-1:0] m;
    m    = {REG_NUM{1'b0}};
    m[a] = (a != {REG_ADDR_W{1'b0}});
    return m;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_wb_fifo.sv
// First-word-fall-through buffer for long-latency writeback results.
// Head entry is visible on rdata_o whenever empty_o is low.
module wb_fifo
  import regfile_wr_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: pipeline writeback (A) has priority,
// long-latency results (B) are buffered, tracked in a pending scoreboard and
// force a pipeline stall if they starve.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  output logic        hazard_o,
  output logic        stall_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic [ENTRY_W-1:0] fifo_head_s;
  wb_entry_t          head_s;
  wr_src_e            win_src_s;
  reg_addr_t          win_addr_s;
  reg_data_t          win_data_s;
  logic               b_retire_s;
  logic [REG_NUM-1:0] clr_mask_s;
  logic [REG_NUM-1:0] set_mask_s;
  logic [REG_NUM-1:0] chk_mask_s;
  logic [REG_NUM-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               starve_sat_s;
  logic               stall_q, stall_d;

  // b_ready is a function of occupancy only, so a same-cycle pop never frees a slot.
  assign b_ready     = ~fifo_full_s & ~rst;
  assign fifo_push_s = b_valid & b_ready;
  assign head_s      = wb_entry_t'(fifo_head_s);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push_s),
    .wdata_i ({b_addr, b_data}),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Write-port arbitration: A always wins, otherwise the buffered B head.
  always_comb begin
    win_src_s = SRC_NONE;
    if (a_valid) begin
      win_src_s = SRC_A;
    end else if (!fifo_empty_s) begin
      win_src_s = SRC_B;
    end else begin
      win_src_s = SRC_NONE;
    end
  end

  // Winning write's address and data.
  always_comb begin
    case (win_src_s)
      SRC_A: begin
        win_addr_s = a_addr;
        win_data_s = a_data;
      end
      SRC_B: begin
        win_addr_s = head_s.addr;
        win_data_s = head_s.data;
      end
      default: begin
        win_addr_s = {REG_ADDR_W{1'b0}};
        win_data_s = {REG_DATA_W{1'b0}};
      end
    endcase
  end

  assign fifo_pop_s = (win_src_s == SRC_B);
  assign b_retire_s = fifo_pop_s;

  // Writes to r0 still retire but never reach the array.
  assign we_o    = (win_src_s != SRC_NONE) & (win_addr_s != {REG_ADDR_W{1'b0}}) & ~rst;
  assign waddr_o = win_addr_s;
  assign wdata_o = win_data_s;

  // Scoreboard masks; OR-ing the set mask last gives a new issue priority over a retire.
  always_comb begin
    clr_mask_s = b_retire_s ? addr_onehot(head_s.addr) : {REG_NUM{1'b0}};
    set_mask_s = iss_valid  ? addr_onehot(iss_addr)    : {REG_NUM{1'b0}};
    chk_mask_s = addr_onehot(chk_rs) | addr_onehot(chk_rt) | addr_onehot(chk_rd);
    sb_d       = (sb_q & ~clr_mask_s) | set_mask_s;
  end

  // A retiring register is forwarded by the register file, so it does not stall decode.
  assign hazard_o = (|(chk_mask_s & sb_q & ~clr_mask_s)) & ~rst;

  // Starvation counter and stall request next-state.
  always_comb begin
    starve_sat_s = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    if (fifo_empty_s || fifo_pop_s) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (starve_sat_s) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1'b1);
    end
    if (fifo_pop_s) begin
      stall_d = 1'b0;
    end else if (starve_sat_s) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Scoreboard, starvation counter and stall register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q         <= {REG_NUM{1'b0}};
      starve_cnt_q <= {CNT_W{1'b0}};
      stall_q      <= 1'b0;
    end else begin
      sb_q         <= sb_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: expected writes go into a queue that a
// negedge monitor drains whenever we_o is high; control outputs are checked inline.
module tb_regfile_wr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr, chk_rs, chk_rt, chk_rd;
  logic [31:0] a_data, b_data;
  logic        b_ready, hazard_o, stall_o, we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  regfile_wr_sched #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
    .hazard_o(hazard_o), .stall_o(stall_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (rst !== 1'b1 && we_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, no write expected", waddr_o, wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (waddr_o !== mon_e.a || wdata_o !== mon_e.d) begin
          errors++;
          $display("FAIL wr_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   waddr_o, wdata_o, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
    iss_valid = 1'b0; iss_addr = 5'd0;
    chk_rs = 5'd0; chk_rt = 5'd0; chk_rd = 5'd0;

    // Reset state
    mid();
    chk("rst_we", we_o, 32'd0);
    chk("rst_b_ready", b_ready, 32'd0);
    chk("rst_hazard", hazard_o, 32'd0);
    chk("rst_stall", stall_o, 32'd0);
    step();
    rst = 1'b0;

    // A and B in the same cycle: A now, B next
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h22;
    expect_wr(5'd5, 32'h11);
    expect_wr(5'd6, 32'h22);
    mid();
    chk("s1_b_ready", b_ready, 32'd1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    mid();
    chk("s1_b_we", we_o, 32'd1);
    step();

    // Starvation: two B pushes under continuous A traffic
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA0 + i;
      expect_wr(5'd1, 32'hA0 + i);
      b_valid = (i < 2);
      b_addr  = (i == 0) ? 5'd7 : 5'd8;
      b_data  = (i == 0) ? 32'h77 : 32'h88;
      mid();
      if (i == 1) chk("s2_b_ready_one", b_ready, 32'd1);
      if (i == 2) chk("s2_b_ready_full", b_ready, 32'd0);
      if (i == 5) chk("s2_stall_early", stall_o, 32'd0);
      if (i >= 6) chk("s2_stall_set", stall_o, 32'd1);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    expect_wr(5'd7, 32'h77);
    expect_wr(5'd8, 32'h88);
    mid();
    chk("s2_stall_hold", stall_o, 32'd1);
    step();
    mid();
    chk("s2_stall_clear", stall_o, 32'd0);
    step();
    mid();
    chk("s2_b_ready_drained", b_ready, 32'd1);
    chk("s2_stall_idle", stall_o, 32'd0);
    step();

    // Scoreboard hazard and retire forwarding
    iss_valid = 1'b1; iss_addr = 5'd9;
    step();
    iss_valid = 1'b0;
    chk_rs = 5'd9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    expect_wr(5'd9, 32'h99);
    mid();
    chk("s3_hazard_rs", hazard_o, 32'd1);
    step();
    b_valid = 1'b0;
    mid();
    chk("s3_hazard_retire", hazard_o, 32'd0);
    step();
    chk_rs = 5'd0; chk_rd = 5'd9;
    mid();
    chk("s3_hazard_cleared", hazard_o, 32'd0);
    step();
    chk_rd = 5'd0;

    // Issue and retire of the same register in one cycle
    iss_valid = 1'b1; iss_addr = 5'd9;
    step();
    iss_valid = 1'b0;
    chk_rt = 5'd9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h5A;
    expect_wr(5'd9, 32'h5A);
    mid();
    chk("s4_hazard_rt", hazard_o, 32'd1);
    step();
    b_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd9;
    mid();
    chk("s4_hazard_retire", hazard_o, 32'd0);
    step();
    iss_valid = 1'b0;
    mid();
    chk("s4_bit_kept", hazard_o, 32'd1);
    step();
    chk_rt = 5'd0;

    // Writes and issue to r0
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hBEEF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    mid();
    chk("s5_a_zero_we", we_o, 32'd0);
    step();
    a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
    mid();
    chk("s5_b_zero_we", we_o, 32'd0);
    chk("s5_hazard_r0", hazard_o, 32'd0);
    step();
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h2;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h10;
    expect_wr(5'd2, 32'h2);
    expect_wr(5'd10, 32'h10);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    mid();
    chk("s5_zero_popped", b_ready, 32'd1);
    step();

    // Reset with a full buffer and pending bits
    iss_valid = 1'b1; iss_addr = 5'd12;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h13;
    expect_wr(5'd3, 32'h33);
    step();
    iss_valid = 1'b0;
    a_data = 32'h34;
    b_addr = 5'd14; b_data = 32'h14;
    expect_wr(5'd3, 32'h34);
    step();
    b_valid = 1'b0;
    a_data = 32'h35;
    chk_rs = 5'd12;
    expect_wr(5'd3, 32'h35);
    mid();
    chk("s6_full", b_ready, 32'd0);
    chk("s6_hazard_pre", hazard_o, 32'd1);
    step();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd15; b_data = 32'h15;
    mid();
    chk("s6_rst_we", we_o, 32'd0);
    chk("s6_rst_b_ready", b_ready, 32'd0);
    chk("s6_rst_hazard", hazard_o, 32'd0);
    step();
    rst = 1'b0;
    b_valid = 1'b0;
    chk_rt = 5'd9;
    mid();
    chk("s6_post_we", we_o, 32'd0);
    chk("s6_post_b_ready", b_ready, 32'd1);
    chk("s6_post_hazard", hazard_o, 32'd0);
    chk("s6_post_stall", stall_o, 32'd0);
    step();
    mid();
    chk("s6_post_we2", we_o, 32'd0);
    step();

    chk("exp_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
